// File: rtl/regfile_mp.sv
// Multi-ported register file with a per-register busy scoreboard.
// Highest write port wins on address collisions; optional same-cycle write-to-read bypass.
module regfile_mp #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NWRITE   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*AW-1:0]     rd_addr,
  output logic [NREAD*WIDTH-1:0]  rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic [NWRITE-1:0]       wr_en,
  input  logic [NWRITE*AW-1:0]    wr_addr,
  input  logic [NWRITE*WIDTH-1:0] wr_data,
  input  logic                    rsv_en,
  input  logic [AW-1:0]           rsv_addr,
  input  logic                    flush,
  output logic [DEPTH-1:0]        busy_vec
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d, wr_hit;
  logic [NWRITE-1:0] wr_eff;

  // Address is backed by storage and is not the hardwired zero register.
  function automatic logic addr_valid(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  always_comb begin
    wr_eff = '0;
    wr_hit = '0;
    for (int p = 0; p < NWRITE; p++) begin
      wr_eff[p] = wr_en[p] && !rst && addr_valid(wr_addr[p*AW +: AW]);
      if (wr_eff[p]) wr_hit[wr_addr[p*AW +: AW]] = 1'b1;
    end
  end

  // A same-cycle reserve overrides the writeback clear: the new producer is still in flight.
  always_comb begin
    busy_d = busy_q & ~wr_hit;
    if (rsv_en && addr_valid(rsv_addr)) busy_d[rsv_addr] = 1'b1;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else begin
      busy_q <= busy_d;
      // Later ports are assigned last, so the highest index wins.
      for (int p = 0; p < NWRITE; p++) begin
        if (wr_eff[p]) mem_q[wr_addr[p*AW +: AW]] <= wr_data[p*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rdata;
    logic             rbusy;

    assign ra = rd_addr[i*AW +: AW];

    always_comb begin
      rdata = '0;
      rbusy = 1'b0;
      if (addr_valid(ra)) begin
        rdata = mem_q[ra];
        rbusy = busy_q[ra];
        if (BYPASS) begin
          for (int p = 0; p < NWRITE; p++) begin
            if (wr_eff[p] && (wr_addr[p*AW +: AW] == ra)) begin
              rdata = wr_data[p*WIDTH +: WIDTH];
              rbusy = 1'b0;
            end
          end
        end
      end
    end

    assign rd_data[i*WIDTH +: WIDTH] = rdata;
    assign rd_busy[i]                = rbusy;
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vectors, expectations queued per cycle and checked by a monitor.
module tb_regfile_mp;

  localparam int KData = 0;
  localparam int KBusy = 1;
  localparam int KVec  = 2;

  // Units: 0 = default, 1 = ZERO_REG=0, 2 = BYPASS=0/NREAD=4/NWRITE=1/DEPTH=24
  typedef struct {
    int          cyc;
    int          unit;
    int          kind;
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_z;
  logic [1:0]  rd_busy, rd_busy_z;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en, flush;
  logic [4:0]  rsv_addr;
  logic [31:0] busy_vec, busy_vec_z;

  logic [19:0]  b_rd_addr;
  logic [127:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic [0:0]   b_wr_en;
  logic [4:0]   b_wr_addr;
  logic [31:0]  b_wr_data;
  logic         b_rsv_en, b_flush;
  logic [4:0]   b_rsv_addr;
  logic [23:0]  b_busy_vec;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .flush(flush), .busy_vec(busy_vec)
  );

  regfile_mp #(.ZERO_REG(1'b0)) dut_z (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_busy(rd_busy_z),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .flush(flush), .busy_vec(busy_vec_z)
  );

  regfile_mp #(.BYPASS(1'b0), .NREAD(4), .NWRITE(1), .DEPTH(24)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .rsv_en(b_rsv_en),
    .rsv_addr(b_rsv_addr), .flush(b_flush), .busy_vec(b_busy_vec)
  );

  function automatic logic [31:0] actual(input int unit, input int kind, input int port);
    logic [31:0] v;
    v = 'x;
    case (unit)
      0: case (kind)
           KData:   v = rd_data[port*32 +: 32];
           KBusy:   v = {31'd0, rd_busy[port]};
           default: v = busy_vec;
         endcase
      1: case (kind)
           KData:   v = rd_data_z[port*32 +: 32];
           KBusy:   v = {31'd0, rd_busy_z[port]};
           default: v = busy_vec_z;
         endcase
      default: case (kind)
           KData:   v = b_rd_data[port*32 +: 32];
           KBusy:   v = {31'd0, b_rd_busy[port]};
           default: v = {8'd0, b_busy_vec};
         endcase
    endcase
    return v;
  endfunction

  // Monitor: outputs are combinational, so each cycle's expectations are due at its negedge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] a;
      e = sb.pop_front();
      a = actual(e.unit, e.kind, e.port);
      checks++;
      if (a !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", e.name, a, e.exp);
      end
    end
  end

  task automatic expect_val(input int unit, input int kind, input int port,
                            input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = cyc; e.unit = unit; e.kind = kind; e.port = port; e.exp = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic idle();
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
    b_rsv_en = 1'b0; b_rsv_addr = '0; b_flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p] = 1'b1; wr_addr[p*5 +: 5] = a; wr_data[p*32 +: 32] = d;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    rd_addr[p*5 +: 5] = a;
  endtask

  task automatic rsv(input logic [4:0] a);
    rsv_en = 1'b1; rsv_addr = a;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    rd(0, 5); rd(1, 7);
    expect_val(0, KData, 0, 32'h0, "reset_rd_data");
    expect_val(0, KBusy, 1, 32'h0, "reset_rd_busy");
    expect_val(0, KVec,  0, 32'h0, "reset_busy_vec");
    expect_val(2, KVec,  0, 32'h0, "b_reset_busy_vec");
    step();

    // Load r5, reserve r7, then reset with a write held.
    wr(0, 5, 32'hDEADBEEF); rsv(7); rd(0, 5);
    expect_val(0, KData, 0, 32'hDEADBEEF, "bypass_r5");
    step();
    rd(0, 5); rd(1, 7);
    expect_val(0, KData, 0, 32'hDEADBEEF, "stored_r5");
    expect_val(0, KBusy, 1, 32'h1, "rsv_r7_busy");
    expect_val(0, KVec,  0, 32'h0000_0080, "rsv_r7_vec");
    step();
    rst = 1'b1;
    wr(0, 5, 32'h12345678); rd(0, 5);
    expect_val(0, KData, 0, 32'hDEADBEEF, "no_bypass_in_rst");
    step();
    rst = 1'b0;
    rd(0, 5); rd(1, 7);
    expect_val(0, KData, 0, 32'h0, "rst_clears_r5");
    expect_val(0, KBusy, 1, 32'h0, "rst_clears_busy_r7");
    expect_val(0, KVec,  0, 32'h0, "rst_busy_vec");
    step();

    // Port priority.
    wr(0, 3, 32'h11); wr(1, 3, 32'h22); rd(0, 3);
    expect_val(0, KData, 0, 32'h22, "prio_bypass");
    step();
    rd(0, 3);
    expect_val(0, KData, 0, 32'h22, "prio_stored");
    step();

    // Zero register.
    wr(0, 0, 32'hFFFFFFFF); rsv(0); rd(0, 0);
    expect_val(0, KData, 0, 32'h0, "r0_bypass_zero");
    expect_val(0, KBusy, 0, 32'h0, "r0_busy_zero");
    step();
    rd(0, 0);
    expect_val(0, KData, 0, 32'h0, "r0_reads_zero");
    expect_val(0, KVec,  0, 32'h0, "r0_never_busy");
    expect_val(1, KData, 0, 32'hFFFFFFFF, "nozero_r0_stored");
    expect_val(1, KVec,  0, 32'h1, "nozero_r0_busy");
    step();

    // Scoreboard reserve then writeback.
    rsv(9); rd(0, 9);
    expect_val(0, KBusy, 0, 32'h0, "rsv_latency");
    step();
    rd(0, 9);
    expect_val(0, KBusy, 0, 32'h1, "r9_busy");
    expect_val(0, KVec,  0, 32'h0000_0200, "r9_vec");
    step();
    wr(1, 9, 32'h1234); rd(0, 9);
    expect_val(0, KData, 0, 32'h1234, "r9_bypass_data");
    expect_val(0, KBusy, 0, 32'h0, "r9_bypass_busy");
    expect_val(0, KVec,  0, 32'h0000_0200, "r9_vec_registered");
    step();
    rd(0, 9);
    expect_val(0, KVec,  0, 32'h0, "r9_vec_cleared");
    expect_val(0, KData, 0, 32'h1234, "r9_stored");
    step();

    // Reserve/write collision, then flush with a reserve.
    rsv(4); wr(0, 4, 32'hAAAA5555);
    step();
    rd(0, 4);
    expect_val(0, KVec,  0, 32'h0000_0010, "collision_rsv_wins");
    expect_val(0, KBusy, 0, 32'h1, "collision_rd_busy");
    expect_val(0, KData, 0, 32'hAAAA5555, "collision_data");
    step();
    flush = 1'b1; rsv(6);
    step();
    rd(0, 4); rd(1, 6);
    expect_val(0, KVec,  0, 32'h0, "flush_vec");
    expect_val(0, KData, 0, 32'hAAAA5555, "flush_keeps_data");
    expect_val(0, KBusy, 1, 32'h0, "flush_drops_rsv");
    step();

    // BYPASS=0, DEPTH=24 instance.
    b_rsv_en = 1'b1; b_rsv_addr = 10;
    b_wr_en = 1'b1; b_wr_addr = 10; b_wr_data = 32'h55;
    b_rd_addr[4:0] = 10;
    expect_val(2, KData, 0, 32'h0, "b_no_bypass_old");
    expect_val(2, KBusy, 0, 32'h0, "b_busy_before");
    step();
    b_wr_en = 1'b1; b_wr_addr = 10; b_wr_data = 32'h66;
    b_rd_addr[4:0] = 10;
    expect_val(2, KData, 0, 32'h55, "b_r10_first");
    expect_val(2, KBusy, 0, 32'h1, "b_busy_registered");
    step();
    b_rd_addr[4:0] = 10;
    b_wr_en = 1'b1; b_wr_addr = 30; b_wr_data = 32'h77;
    b_rsv_en = 1'b1; b_rsv_addr = 30;
    b_rd_addr[9:5] = 30; b_rd_addr[14:10] = 30;
    expect_val(2, KData, 0, 32'h66, "b_r10_second");
    expect_val(2, KBusy, 0, 32'h0, "b_busy_cleared");
    expect_val(2, KVec,  0, 32'h0, "b_vec_cleared");
    expect_val(2, KData, 1, 32'h0, "b_addr30_zero");
    step();
    b_wr_en = 1'b1; b_wr_addr = 23; b_wr_data = 32'hCAFE0023;
    b_rd_addr[9:5] = 30; b_rd_addr[19:15] = 23;
    expect_val(2, KData, 1, 32'h0, "b_addr30_ignored");
    expect_val(2, KBusy, 1, 32'h0, "b_addr30_not_busy");
    expect_val(2, KVec,  0, 32'h0, "b_rsv30_ignored");
    expect_val(2, KData, 3, 32'h0, "b_r23_old");
    step();
    b_rd_addr[19:15] = 23; b_rd_addr[4:0] = 10;
    expect_val(2, KData, 3, 32'hCAFE0023, "b_r23_stored");
    expect_val(2, KData, 0, 32'h66, "b_r10_intact");
    step();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      errors += sb.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
